// File: rtl/multdiv_pkg.sv
// ============================================================================
// multdiv_pkg -- shared state encoding and sizing constants for multdiv_unit
// Revision: 1.0
// ============================================================================
`default_nettype none

package multdiv_pkg;

  localparam int c_default_width = 32;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    MULT = 3'd1,
    DIV  = 3'd2,
    FIX  = 3'd3,
    DONE = 3'd4
  } state_t;

  // One shift-add or shift-subtract step per operand bit.
  function automatic int iter_count(input int width);
    return width;
  endfunction

  localparam int c_iter_count = iter_count(c_default_width);

endpackage

`default_nettype wire

// File: rtl/multdiv_counter.sv
// ============================================================================
// multdiv_counter -- loadable down-counter flagging the final iteration
// Revision: 1.0
// ============================================================================
`default_nettype none

module multdiv_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_dec,
  output logic             o_last
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_last = (r_count == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/multdiv_unit.sv
// ============================================================================
// multdiv_unit -- iterative signed multiply / divide (shift-add, restoring).
// Define MULTDIV_OVF_EN to flag multiplies whose product overflows WIDTH bits.
// Revision: 1.0
// ============================================================================
`default_nettype none

module multdiv_unit
  import multdiv_pkg::*;
#(
  parameter int WIDTH = c_default_width
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] data_operandA,
  input  logic [WIDTH-1:0] data_operandB,
  input  logic             ctrl_MULT,
  input  logic             ctrl_DIV,
  output logic [WIDTH-1:0] data_result,
  output logic             data_exception,
  output logic             data_resultRDY,
  output logic             busy
);

  localparam int                c_cnt_w = $clog2(iter_count(WIDTH) + 1);
  localparam logic [c_cnt_w-1:0] c_iters = c_cnt_w'(iter_count(WIDTH));

  state_t r_state;
  state_t w_next;

  logic             w_start;
  logic             w_last;
  logic             w_iterating;
  logic [WIDTH-1:0] w_mag_a;
  logic [WIDTH-1:0] w_mag_b;

  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_lo;
  logic [WIDTH-1:0] r_opnd;
  logic             r_neg;
  logic             r_is_mult;
  logic             r_div_zero;
  logic [WIDTH-1:0] r_result;
  logic             r_exc;

  logic [WIDTH:0]   w_mul_sum;
  logic [WIDTH:0]   w_div_shift;
  logic             w_div_ge;
  logic [WIDTH-1:0] w_div_diff;
  logic [WIDTH-1:0] w_signed_lo;
  logic [WIDTH-1:0] w_mul_res;
  logic             w_mul_exc;
  logic             w_div_ovf;

  assign w_start     = ctrl_MULT | ctrl_DIV;
  assign w_iterating = (r_state == MULT) || (r_state == DIV);
  assign w_mag_a     = data_operandA[WIDTH-1] ? -data_operandA : data_operandA;
  assign w_mag_b     = data_operandB[WIDTH-1] ? -data_operandB : data_operandB;

  multdiv_counter #(
    .CNT_W (c_cnt_w)
  ) u_counter (
    .clock        (clock),
    .reset        (reset),
    .i_load       (w_start),
    .i_load_value (c_iters),
    .i_dec        (w_iterating),
    .o_last       (w_last)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // A start pulse restarts from any state, aborting whatever was in flight.
  always_comb begin
    w_next = r_state;
    if (w_start) begin
      w_next = ctrl_MULT ? MULT : DIV;
    end else begin
      case (r_state)
        IDLE:    w_next = IDLE;
        MULT:    if (w_last) w_next = FIX;
        DIV: begin
          if (r_div_zero)  w_next = DONE;
          else if (w_last) w_next = FIX;
        end
        FIX:     w_next = DONE;
        DONE:    w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end
  end

  always_comb begin
    busy           = 1'b0;
    data_resultRDY = 1'b0;
    case (r_state)
      MULT, DIV, FIX: busy           = 1'b1;
      DONE:           data_resultRDY = 1'b1;
      default:        ;
    endcase
  end

  // r_acc:r_lo is the product shifting right, or remainder:quotient shifting left.
  assign w_mul_sum   = {1'b0, r_acc} + (r_lo[0] ? {1'b0, r_opnd} : '0);
  assign w_div_shift = {r_acc, r_lo[WIDTH-1]};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_opnd});
  assign w_div_diff  = w_div_shift[WIDTH-1:0] - r_opnd;
  assign w_signed_lo = r_neg ? -r_lo : r_lo;
  // A positive quotient with its MSB set only arises from -2^(WIDTH-1) / -1.
  assign w_div_ovf   = ~r_neg & r_lo[WIDTH-1];

`ifdef MULTDIV_OVF_EN
  logic [2*WIDTH-1:0] w_prod;
  assign w_prod    = r_neg ? -{r_acc, r_lo} : {r_acc, r_lo};
  assign w_mul_res = w_prod[WIDTH-1:0];
  assign w_mul_exc = ~((&w_prod[2*WIDTH-1:WIDTH-1]) | ~(|w_prod[2*WIDTH-1:WIDTH-1]));
`else
  assign w_mul_res = w_signed_lo;
  assign w_mul_exc = 1'b0;
`endif

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_lo       <= '0;
      r_opnd     <= '0;
      r_neg      <= 1'b0;
      r_is_mult  <= 1'b0;
      r_div_zero <= 1'b0;
      r_result   <= '0;
      r_exc      <= 1'b0;
    end else if (w_start) begin
      r_acc      <= '0;
      r_neg      <= data_operandA[WIDTH-1] ^ data_operandB[WIDTH-1];
      r_is_mult  <= ctrl_MULT;
      if (ctrl_MULT) begin
        r_lo       <= w_mag_b;
        r_opnd     <= w_mag_a;
        r_div_zero <= 1'b0;
      end else begin
        r_lo       <= w_mag_a;
        r_opnd     <= w_mag_b;
        r_div_zero <= (data_operandB == '0);
      end
    end else begin
      case (r_state)
        MULT: begin
          r_acc <= w_mul_sum[WIDTH:1];
          r_lo  <= {w_mul_sum[0], r_lo[WIDTH-1:1]};
        end
        DIV: begin
          if (r_div_zero) begin
            r_result <= '0;
            r_exc    <= 1'b1;
          end else begin
            r_acc <= w_div_ge ? w_div_diff : w_div_shift[WIDTH-1:0];
            r_lo  <= {r_lo[WIDTH-2:0], w_div_ge};
          end
        end
        FIX: begin
          if (r_is_mult) begin
            r_result <= w_mul_res;
            r_exc    <= w_mul_exc;
          end else begin
            r_result <= w_signed_lo;
            r_exc    <= w_div_ovf;
          end
        end
        default: ;
      endcase
    end
  end

  assign data_result    = r_result;
  assign data_exception = r_exc;

endmodule

`default_nettype wire

// File: tb/tb_multdiv_unit.sv
// ============================================================================
// tb_multdiv_unit -- directed table, corner sequences and random ops vs a model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_multdiv_unit;

  localparam int W = 32;
`ifdef MULTDIV_OVF_EN
  localparam bit c_ovf = 1'b1;
`else
  localparam bit c_ovf = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] data_operandA = '0;
  logic [W-1:0] data_operandB = '0;
  logic         ctrl_MULT = 1'b0;
  logic         ctrl_DIV = 1'b0;
  logic [W-1:0] data_result;
  logic         data_exception;
  logic         data_resultRDY;
  logic         busy;

  int errors = 0;
  int checks = 0;

  multdiv_unit #(.WIDTH(W)) dut (
    .clock          (clock),
    .reset          (reset),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_result    (data_result),
    .data_exception (data_exception),
    .data_resultRDY (data_resultRDY),
    .busy           (busy)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          is_mult;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] res;
    bit          exc;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Reference: plain signed arithmetic on the operand values.
  function automatic void model(input bit m, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output bit e, output int lat);
    longint p;
    lat = 34;
    e   = 1'b0;
    if (m) begin
      p = longint'($signed(a)) * longint'($signed(b));
      r = p[31:0];
      e = c_ovf && ((p > 64'sd2147483647) || (p < -64'sd2147483648));
    end else if (b == 32'd0) begin
      r   = 32'd0;
      e   = 1'b1;
      lat = 2;
    end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      r = 32'h8000_0000;
      e = 1'b1;
    end else begin
      r = $signed(a) / $signed(b);
    end
  endfunction

  task automatic pulse_start(input bit m, input logic [31:0] a, input logic [31:0] b);
    @(negedge clock);
    ctrl_MULT     = m;
    ctrl_DIV      = !m;
    data_operandA = a;
    data_operandB = b;
    @(posedge clock);
    #1;
    ctrl_MULT     = 1'b0;
    ctrl_DIV      = 1'b0;
    data_operandA = $urandom;
    data_operandB = $urandom;
  endtask

  // Latency counts the sampling cycle as 1: RDY seen n edges after the
  // start edge is reported as n+1.
  task automatic run_op(input string nm, input bit m, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] er, input bit ee, input int el);
    int n;
    pulse_start(m, a, b);
    chk({nm, " busy"}, 32'(busy), 32'd1);
    n = 0;
    while (!data_resultRDY && n < 60) begin
      @(posedge clock);
      #1;
      n++;
    end
    chk({nm, " latency"}, 32'(n + 1), 32'(el));
    chk({nm, " result"}, data_result, er);
    chk({nm, " exception"}, 32'(data_exception), 32'(ee));
    @(posedge clock);
    #1;
    chk({nm, " rdy one-shot"}, 32'({data_resultRDY, busy}), 32'd0);
    chk({nm, " result held"}, data_result, er);
  endtask

  initial begin
    logic [31:0] r, a, b;
    bit          e, m;
    int          lat, seen, ai, bi;

    vecs[0] = '{1'b1, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0,  34};
    vecs[1] = '{1'b0, 32'hFFFF_FF9C,  32'd7,         32'hFFFF_FFF2, 1'b0,  34};
    vecs[2] = '{1'b0, 32'd5,          32'd0,         32'd0,         1'b1,  2};
    vecs[3] = '{1'b1, 32'h0001_0000,  32'h0001_0000, 32'd0,         c_ovf, 34};
    vecs[4] = '{1'b0, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 1'b1,  34};
    vecs[5] = '{1'b0, 32'h8000_0000,  32'd1,         32'h8000_0000, 1'b0,  34};
    vecs[6] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, c_ovf, 34};
    vecs[7] = '{1'b0, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 1'b0,  34};
    vecs[8] = '{1'b1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'd1,         1'b0,  34};
    vecs[9] = '{1'b0, 32'd100,        32'hFFFF_FFF9, 32'hFFFF_FFF2, 1'b0,  34};

    repeat (3) @(posedge clock);
    #1;
    chk("reset result", data_result, 32'd0);
    chk("reset exception", 32'(data_exception), 32'd0);
    chk("reset rdy", 32'(data_resultRDY), 32'd0);
    chk("reset busy", 32'(busy), 32'd0);
    @(negedge clock);
    reset = 1'b1;

    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].is_mult, vecs[i].a, vecs[i].b,
             vecs[i].res, vecs[i].exc, vecs[i].lat);
    end

    // Abort: a divide is overtaken by a multiply at cycle 10.
    pulse_start(1'b0, 32'd9, 32'd3);
    seen = 0;
    repeat (9) begin
      @(posedge clock);
      #1;
      if (data_resultRDY) seen++;
    end
    chk("abort no early rdy", 32'(seen), 32'd0);
    run_op("abort mult", 1'b1, 32'd4, 32'd5, 32'd20, 1'b0, 34);

    // Reset mid-multiply, with a start pulse attempted while reset is low.
    pulse_start(1'b1, 32'd3, 32'd3);
    repeat (14) @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    chk("midreset result", data_result, 32'd0);
    chk("midreset exception", 32'(data_exception), 32'd0);
    chk("midreset rdy", 32'(data_resultRDY), 32'd0);
    chk("midreset busy", 32'(busy), 32'd0);
    @(negedge clock);
    ctrl_MULT     = 1'b1;
    data_operandA = 32'd2;
    data_operandB = 32'd2;
    @(negedge clock);
    ctrl_MULT = 1'b0;
    reset     = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clock);
      #1;
      if (data_resultRDY || busy) seen++;
    end
    chk("postreset quiet", 32'(seen), 32'd0);

    for (int i = 0; i < 40; i++) begin
      m = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: begin
          a = $urandom;
          b = $urandom;
        end
        1: begin
          ai = int'($urandom_range(0, 200)) - 100;
          bi = int'($urandom_range(0, 200)) - 100;
          a  = ai;
          b  = bi;
        end
        2: begin
          a = $urandom;
          b = ($urandom_range(0, 1) == 0) ? 32'd0 : 32'hFFFF_FFFF;
        end
        default: begin
          a = 32'h8000_0000;
          b = ($urandom_range(0, 1) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
      endcase
      model(m, a, b, r, e, lat);
      run_op($sformatf("rand%0d", i), m, a, b, r, e, lat);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
